// File: rtl/bcd_digit_counter.sv
// BCD digit (0-9) for a 7-segment decoder: debounced up/down keys, switch load and
// prescaled auto-increment, with carry/borrow pulses for chaining digits.

module bcd_key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic          db_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            db_q      <= 1'b1;
            db_prev_q <= 1'b1;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= key_ni;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            press_q   <= db_prev_q & ~db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign press_o = press_q;
endmodule

module bcd_digit_counter #(
    parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
    parameter int unsigned AUTO_TICK_CYCLES = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_UP_N,
    input  logic       KEY_DN_N,
    input  logic       AUTO_EN,
    input  logic       LOAD_EN,
    input  logic [3:0] LOAD_VAL,
    output logic [3:0] DIGIT,
    output logic       CARRY,
    output logic       BORROW
);
    localparam int unsigned PW = $clog2(AUTO_TICK_CYCLES + 1);

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_INC,
        ACT_DEC
    } action_e;

    logic          up_press, dn_press;
    logic          tick;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    digit_q, digit_d;
    logic          carry_q, carry_d;
    logic          borrow_q, borrow_d;
    action_e       action;

    bcd_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
        .clk_i   (CLOCK_50),
        .rst_ni  (RESET_N),
        .key_ni  (KEY_UP_N),
        .press_o (up_press)
    );

    bcd_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dn (
        .clk_i   (CLOCK_50),
        .rst_ni  (RESET_N),
        .key_ni  (KEY_DN_N),
        .press_o (dn_press)
    );

    assign tick = AUTO_EN && (pre_q == PW'(AUTO_TICK_CYCLES - 1));

    always_comb begin
        pre_d = '0;
        if (AUTO_EN && !tick) begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Load wins outright; simultaneous presses cancel; a tick only counts when no key fired.
    always_comb begin
        action = ACT_HOLD;
        if (LOAD_EN) begin
            action = (LOAD_VAL <= 4'd9) ? ACT_LOAD : ACT_HOLD;
        end else if (up_press && dn_press) begin
            action = ACT_HOLD;
        end else if (up_press) begin
            action = ACT_INC;
        end else if (dn_press) begin
            action = ACT_DEC;
        end else if (tick) begin
            action = ACT_INC;
        end
    end

    always_comb begin
        digit_d  = digit_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        unique case (action)
            ACT_LOAD: digit_d = LOAD_VAL;
            ACT_INC: begin
                if (digit_q == 4'd9) begin
                    digit_d = 4'd0;
                    carry_d = 1'b1;
                end else begin
                    digit_d = digit_q + 4'd1;
                end
            end
            ACT_DEC: begin
                if (digit_q == 4'd0) begin
                    digit_d  = 4'd9;
                    borrow_d = 1'b1;
                end else begin
                    digit_d = digit_q - 4'd1;
                end
            end
            default: digit_d = digit_q;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_q    <= '0;
            digit_q  <= 4'd0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            digit_q  <= digit_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign DIGIT  = digit_q;
    assign CARRY  = carry_q;
    assign BORROW = borrow_q;
endmodule

// File: tb/tb_bcd_digit_counter.sv
// Random and directed stimulus for bcd_digit_counter, checked every cycle against a
// sample-history model of debounce, prescale and the digit update rules.

module tb_bcd_digit_counter;
    localparam int D = 4;
    localparam int T = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_up_n = 1'b1;
    logic       key_dn_n = 1'b1;
    logic       auto_en = 1'b0;
    logic       load_en = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] digit;
    logic       carry;
    logic       borrow;

    int vectors = 0;
    int miscompares = 0;
    int carry_seen = 0;
    int borrow_seen = 0;

    always #5 clk = ~clk;

    bcd_digit_counter #(
        .DEBOUNCE_CYCLES  (D),
        .AUTO_TICK_CYCLES (T)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .KEY_UP_N (key_up_n),
        .KEY_DN_N (key_dn_n),
        .AUTO_EN  (auto_en),
        .LOAD_EN  (load_en),
        .LOAD_VAL (load_val),
        .DIGIT    (digit),
        .CARRY    (carry),
        .BORROW   (borrow)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Behavioural model: raw key samples per edge (newest at index 0), a run length of
    // enabled edges for the prescaler, and the digit itself as a plain integer.
    bit up_hist[$];
    bit dn_hist[$];
    bit m_up_db, m_dn_db;
    bit up_f1, up_f2, dn_f1, dn_f2;
    int run_len;
    int m_digit;
    bit m_carry, m_borrow;

    // The debounced level flips once the D samples that reached the synchronizer output
    // (two edges old and older) all disagree with it.
    function automatic bit window_flips(input bit h[$], input bit db);
        for (int i = 2; i <= D + 1; i++) begin
            if (h[i] == db) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        up_hist.delete();
        dn_hist.delete();
        for (int i = 0; i < D + 2; i++) begin
            up_hist.push_back(1'b1);
            dn_hist.push_back(1'b1);
        end
        m_up_db  = 1'b1;
        m_dn_db  = 1'b1;
        up_f1    = 1'b0;
        up_f2    = 1'b0;
        dn_f1    = 1'b0;
        dn_f2    = 1'b0;
        run_len  = 0;
        m_digit  = 0;
        m_carry  = 1'b0;
        m_borrow = 1'b0;
    endtask

    task automatic model_step();
        bit up_ev, dn_ev, up_fl, dn_fl, tck;
        up_hist.push_front(key_up_n);
        void'(up_hist.pop_back());
        dn_hist.push_front(key_dn_n);
        void'(dn_hist.pop_back());

        // A press reaches the digit two edges after the debounced level falls.
        up_ev = up_f2;
        dn_ev = dn_f2;
        up_fl = 1'b0;
        dn_fl = 1'b0;
        if (window_flips(up_hist, m_up_db)) begin
            up_fl   = m_up_db;
            m_up_db = ~m_up_db;
        end
        if (window_flips(dn_hist, m_dn_db)) begin
            dn_fl   = m_dn_db;
            m_dn_db = ~m_dn_db;
        end
        up_f2 = up_f1;
        up_f1 = up_fl;
        dn_f2 = dn_f1;
        dn_f1 = dn_fl;

        run_len = auto_en ? run_len + 1 : 0;
        tck     = auto_en && (run_len % T == 0);

        m_carry  = 1'b0;
        m_borrow = 1'b0;
        if (load_en) begin
            if (load_val <= 9) m_digit = load_val;
        end else if (up_ev && dn_ev) begin
            m_digit = m_digit;
        end else if (up_ev || (!dn_ev && tck)) begin
            if (m_digit == 9) begin
                m_digit = 0;
                m_carry = 1'b1;
            end else begin
                m_digit = m_digit + 1;
            end
        end else if (dn_ev) begin
            if (m_digit == 0) begin
                m_digit  = 9;
                m_borrow = 1'b1;
            end else begin
                m_digit = m_digit - 1;
            end
        end
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        check("digit", digit, m_digit);
        check("carry", carry, m_carry);
        check("borrow", borrow, m_borrow);
        if (carry === 1'b1)  carry_seen++;
        if (borrow === 1'b1) borrow_seen++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit up, input bit dn, input int hold, input int rel);
        if (up) key_up_n = 1'b0;
        if (dn) key_dn_n = 1'b0;
        cyc(hold);
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        cyc(rel);
    endtask

    task automatic load(input logic [3:0] v);
        load_en  = 1'b1;
        load_val = v;
        cyc(1);
        load_en = 1'b0;
    endtask

    task automatic async_reset_check(input string name);
        rst_n = 1'b0;
        #1;
        check({name, "_digit"}, digit, 0);
        check({name, "_carry"}, carry, 0);
        check({name, "_borrow"}, borrow, 0);
    endtask

    initial begin
        int r;
        cyc(3);
        rst_n = 1'b1;
        cyc(20);
        check("idle_after_reset", digit, 0);

        // First press: update lands exactly D+4 edges after the first low sample.
        key_up_n = 1'b0;
        for (int i = 1; i <= D + 3; i++) begin
            cyc(1);
            check("up_latency_wait", digit, 0);
        end
        cyc(1);
        check("up_first_step", digit, 1);
        check("model_first_step", m_digit, 1);
        cyc(12);
        key_up_n = 1'b1;
        cyc(10);
        check("up_single_step", digit, 1);

        carry_seen = 0;
        repeat (9) press(1'b1, 1'b0, 10, 10);
        check("up_wrap_digit", digit, 0);
        check("up_wrap_carry_count", carry_seen, 1);

        borrow_seen = 0;
        press(1'b0, 1'b1, 20, 10);
        check("dn_wrap_digit", digit, 9);
        check("dn_wrap_borrow_count", borrow_seen, 1);
        press(1'b0, 1'b1, 3, 15);
        check("dn_glitch_ignored", digit, 9);

        load(4'd7);
        check("load_7", digit, 7);
        load(4'd12);
        check("load_12_holds", digit, 7);
        cyc(2);

        // Load held across the cycle the debounced up event arrives.
        key_up_n = 1'b0;
        cyc(D + 2);
        load_en  = 1'b1;
        load_val = 4'd3;
        cyc(3);
        load_en = 1'b0;
        cyc(10);
        key_up_n = 1'b1;
        cyc(10);
        check("load_beats_event", digit, 3);

        @(posedge clk);
        #2;
        async_reset_check("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(20);
        check("post_reset_idle", digit, 0);

        load(4'd8);
        auto_en = 1'b1;
        cyc(T);
        check("auto_to_9", digit, 9);
        cyc(T - 1);
        check("auto_hold_9", digit, 9);
        cyc(1);
        check("auto_wrap_0", digit, 0);
        check("auto_wrap_carry", carry, 1);
        auto_en = 1'b0;
        cyc(25);
        check("auto_off_frozen", digit, 0);
        auto_en = 1'b1;
        cyc(T - 1);
        check("prescaler_cleared", digit, 0);
        cyc(1);
        check("auto_restart_step", digit, 1);
        auto_en = 1'b0;

        load(4'd5);
        press(1'b1, 1'b1, 15, 10);
        check("up_dn_cancel", digit, 5);

        // Reset with the prescaler part-way and the up key mid-debounce.
        auto_en = 1'b1;
        cyc(2);
        key_up_n = 1'b0;
        cyc(4);
        #1;
        rst_n   = 1'b0;
        auto_en = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        for (int i = 1; i <= D + 3; i++) begin
            cyc(1);
            check("held_key_redebounce_wait", digit, 0);
        end
        cyc(1);
        check("held_key_one_step", digit, 1);
        cyc(20);
        key_up_n = 1'b1;
        cyc(10);
        check("held_key_no_repeat", digit, 1);

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 30) begin
                press(1'b1, 1'b0, $urandom_range(1, 10), $urandom_range(1, 10));
            end else if (r < 50) begin
                press(1'b0, 1'b1, $urandom_range(1, 10), $urandom_range(1, 10));
            end else if (r < 58) begin
                press(1'b1, 1'b1, $urandom_range(1, 10), $urandom_range(1, 10));
            end else if (r < 68) begin
                load_en  = 1'b1;
                load_val = 4'($urandom_range(0, 15));
                cyc($urandom_range(1, 3));
                load_en = 1'b0;
            end else if (r < 80) begin
                auto_en = ~auto_en;
                cyc($urandom_range(1, 25));
            end else if (r < 84) begin
                @(posedge clk);
                #($urandom_range(1, 4));
                async_reset_check("rand_reset");
                @(negedge clk);
                cyc($urandom_range(0, 2));
                rst_n = 1'b1;
            end else begin
                for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
                    key_up_n = 1'($urandom_range(0, 1));
                    key_dn_n = 1'($urandom_range(0, 1));
                    cyc(1);
                end
                key_up_n = 1'b1;
                key_dn_n = 1'b1;
                cyc($urandom_range(1, 6));
            end
        end
        auto_en = 1'b0;
        cyc(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
